seq_detect_param: RTL and testbench

//  Parametrised serial bit-pattern detector; successor to the fixed 1001 detector.

---
 rtl/seq_detect_param.sv | 125 ++++++++++++
 tb/tb_seq_detect_param.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/seq_detect_param.sv
// -----------------------------------------------------------------------------
// seq_detect_param
//   Parametrised serial bit-pattern detector. One bit is shifted in per enabled
//   clock. A match is declared when the most recent PAT_LEN bits equal the
//   run-time-loadable pattern register. A registered one-cycle pulse is raised
//   for each match, and a saturating counter tracks how many matches occurred.
//
// Parameters
//   PAT_LEN  pattern length in bits (2..32)
//   PATTERN  reset value of the pattern register, MSB = first bit received
//   OVERLAP  1: matches may share bits, 0: history is dropped after a match
//   CNT_W    width of the match counter
//
// Ports
//   clk        in   rising-edge clock
//   reset      in   asynchronous, active-high reset
//   en         in   sample enable; inp_1 is consumed only when en=1
//   inp_1      in   serial data bit
//   pat_load   in   load pat_in into the pattern register (wins over en)
//   pat_in     in   new pattern, MSB = first bit
//   cnt_clr    in   synchronous clear of match_cnt and cnt_sat
//   out        out  registered match pulse, one cycle per match
//   match_cnt  out  saturating number of matches since reset/clear
//   cnt_sat    out  sticky flag: match_cnt reached all-ones on a match
// -----------------------------------------------------------------------------
module seq_detect_param #(
  parameter int                 PAT_LEN = 4,
  parameter logic [PAT_LEN-1:0] PATTERN = 4'b1001,
  parameter bit                 OVERLAP = 1'b1,
  parameter int                 CNT_W   = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic               inp_1,
  input  logic               pat_load,
  input  logic [PAT_LEN-1:0] pat_in,
  input  logic               cnt_clr,
  output logic               out,
  output logic [CNT_W-1:0]   match_cnt,
  output logic               cnt_sat
);

  localparam int                FILL_W    = $clog2(PAT_LEN + 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_LEN);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  logic [PAT_LEN-1:0] shreg_q, shreg_d;
  logic [FILL_W-1:0]  fill_q, fill_d;
  logic [PAT_LEN-1:0] pat_q, pat_d;
  logic               out_q, out_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               sat_q, sat_d;

  logic [PAT_LEN-1:0] shreg_shift;
  logic [FILL_W-1:0]  fill_inc;
  logic               match;
  logic [CNT_W-1:0]   cnt_base;
  logic               sat_base;

  // Detection path: shift, fill tracking, compare.
  always_comb begin
    shreg_d     = shreg_q;
    fill_d      = fill_q;
    pat_d       = pat_q;
    out_d       = 1'b0;
    match       = 1'b0;
    shreg_shift = {shreg_q[PAT_LEN-2:0], inp_1};
    // fill counts valid history bits so zero-filled history never matches
    fill_inc    = (fill_q == FILL_FULL) ? fill_q : fill_q + FILL_W'(1);

    if (pat_load) begin
      // a reload discards any partial match built against the old pattern
      pat_d   = pat_in;
      shreg_d = '0;
      fill_d  = '0;
    end else if (en) begin
      match   = (fill_inc == FILL_FULL) && (shreg_shift == pat_q);
      out_d   = match;
      shreg_d = shreg_shift;
      // non-overlapping mode restarts collection after a hit
      fill_d  = (match && !OVERLAP) ? '0 : fill_inc;
    end
  end

  // Counter path: clear first, then count a coincident match.
  always_comb begin
    cnt_base = cnt_clr ? '0   : cnt_q;
    sat_base = cnt_clr ? 1'b0 : sat_q;
    cnt_d    = cnt_base;
    sat_d    = sat_base;
    if (match) begin
      if (cnt_base != CNT_MAX) begin
        cnt_d = cnt_base + CNT_W'(1);
      end
      // covers both "just became" and "already was" all-ones
      if (cnt_d == CNT_MAX) begin
        sat_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shreg_q <= '0;
      fill_q  <= '0;
      pat_q   <= PATTERN;
      out_q   <= 1'b0;
      cnt_q   <= '0;
      sat_q   <= 1'b0;
    end else begin
      shreg_q <= shreg_d;
      fill_q  <= fill_d;
      pat_q   <= pat_d;
      out_q   <= out_d;
      cnt_q   <= cnt_d;
      sat_q   <= sat_d;
    end
  end

  assign out       = out_q;
  assign match_cnt = cnt_q;
  assign cnt_sat   = sat_q;

endmodule

// File: tb/tb_seq_detect_param.sv
// -----------------------------------------------------------------------------
// tb_seq_detect_param
//   Drives three detector instances with shared stimulus:
//     a: defaults (1001, overlapping, 8-bit counter)
//     b: non-overlapping, 2-bit counter
//     c: reset pattern 0001, overlapping, 3-bit counter
//   Each instance is compared against a queue-based reference model that keeps
//   the bits received since the last history loss and checks its tail.
// -----------------------------------------------------------------------------
module tb_seq_detect_param;

  typedef bit bq_t[$];

  logic       clk;
  logic       reset;
  logic       en;
  logic       inp_1;
  logic       pat_load;
  logic [3:0] pat_in;
  logic       cnt_clr;

  logic       out_a, out_b, out_c;
  logic [7:0] cnt_a;
  logic [1:0] cnt_b;
  logic [2:0] cnt_c;
  logic       sat_a, sat_b, sat_c;

  int total;
  int bad;
  int txn;

  // reference model state, index 0=a, 1=b, 2=c
  bq_t        hist [3];
  int         mpat [3];
  int         mcnt [3];
  bit         msat [3];
  bit         mout [3];
  int         m_ov      [3] = '{1, 0, 1};
  int         m_max     [3] = '{255, 3, 7};
  int         m_rst_pat [3] = '{9, 9, 1};

  seq_detect_param #(.PAT_LEN(4), .PATTERN(4'b1001), .OVERLAP(1'b1), .CNT_W(8)) dut_a (
    .clk(clk), .reset(reset), .en(en), .inp_1(inp_1), .pat_load(pat_load),
    .pat_in(pat_in), .cnt_clr(cnt_clr), .out(out_a), .match_cnt(cnt_a), .cnt_sat(sat_a)
  );

  seq_detect_param #(.PAT_LEN(4), .PATTERN(4'b1001), .OVERLAP(1'b0), .CNT_W(2)) dut_b (
    .clk(clk), .reset(reset), .en(en), .inp_1(inp_1), .pat_load(pat_load),
    .pat_in(pat_in), .cnt_clr(cnt_clr), .out(out_b), .match_cnt(cnt_b), .cnt_sat(sat_b)
  );

  seq_detect_param #(.PAT_LEN(4), .PATTERN(4'b0001), .OVERLAP(1'b1), .CNT_W(3)) dut_c (
    .clk(clk), .reset(reset), .en(en), .inp_1(inp_1), .pat_load(pat_load),
    .pat_in(pat_in), .cnt_clr(cnt_clr), .out(out_c), .match_cnt(cnt_c), .cnt_sat(sat_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (txn %0d)", tag, obs, exp, txn);
    end
  endtask

  function automatic int hist_value(input bq_t q);
    int v = 0;
    foreach (q[k]) v = v * 2 + int'(q[k]);
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      hist[i].delete();
      mpat[i] = m_rst_pat[i];
      mcnt[i] = 0;
      msat[i] = 1'b0;
      mout[i] = 1'b0;
    end
  endtask

  task automatic model_edge(input bit e, input bit b, input bit ld, input int pin, input bit clr);
    bit m;
    for (int i = 0; i < 3; i++) begin
      m = 1'b0;
      if (ld) begin
        hist[i].delete();
        mpat[i] = pin;
      end else if (e) begin
        hist[i].push_back(b);
        if (hist[i].size() > 4) void'(hist[i].pop_front());
        if (hist[i].size() == 4 && hist_value(hist[i]) == mpat[i]) m = 1'b1;
        if (m && m_ov[i] == 0) hist[i].delete();
      end
      mout[i] = m;
      if (clr) begin
        mcnt[i] = 0;
        msat[i] = 1'b0;
      end
      if (m) begin
        if (mcnt[i] < m_max[i]) mcnt[i]++;
        if (mcnt[i] == m_max[i]) msat[i] = 1'b1;
      end
    end
  endtask

  task automatic check_outputs();
    check_val("a_out", 32'(out_a), 32'(mout[0]));
    check_val("a_cnt", 32'(cnt_a), 32'(mcnt[0]));
    check_val("a_sat", 32'(sat_a), 32'(msat[0]));
    check_val("b_out", 32'(out_b), 32'(mout[1]));
    check_val("b_cnt", 32'(cnt_b), 32'(mcnt[1]));
    check_val("b_sat", 32'(sat_b), 32'(msat[1]));
    check_val("c_out", 32'(out_c), 32'(mout[2]));
    check_val("c_cnt", 32'(cnt_c), 32'(mcnt[2]));
    check_val("c_sat", 32'(sat_c), 32'(msat[2]));
  endtask

  task automatic step(input bit e, input bit b, input bit ld, input logic [3:0] pin, input bit clr);
    @(negedge clk);
    en       = e;
    inp_1    = b;
    pat_load = ld;
    pat_in   = pin;
    cnt_clr  = clr;
    model_edge(e, b, ld, int'(pin), clr);
    @(posedge clk);
    #1;
    txn++;
    check_outputs();
    $display("txn %0d en=%0b bit=%0b ld=%0b pat=%b clr=%0b -> out=%0b%0b%0b cnt=%0d/%0d/%0d sat=%0b%0b%0b",
             txn, e, b, ld, pin, clr, out_a, out_b, out_c, cnt_a, cnt_b, cnt_c, sat_a, sat_b, sat_c);
    en       = 1'b0;
    pat_load = 1'b0;
    cnt_clr  = 1'b0;
  endtask

  // send n bits, bits[n-1] first
  task automatic send(input int n, input logic [15:0] bits);
    for (int k = n - 1; k >= 0; k--) step(1'b1, bits[k], 1'b0, 4'h0, 1'b0);
  endtask

  // asserted mid-cycle; outputs must clear without waiting for an edge
  task automatic do_reset();
    #1;
    reset = 1'b1;
    model_reset();
    #1;
    txn++;
    check_outputs();
    $display("txn %0d async reset", txn);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    total    = 0;
    bad      = 0;
    txn      = 0;
    reset    = 1'b1;
    en       = 1'b0;
    inp_1    = 1'b0;
    pat_load = 1'b0;
    pat_in   = 4'h0;
    cnt_clr  = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check_outputs();
    reset = 1'b0;

    // single match, then async drop of the pulse
    send(4, 16'b1001);
    check_val("t1_out_a", 32'(out_a), 32'd1);
    do_reset();
    check_val("t5_out_a_async", 32'(out_a), 32'd0);

    // overlap vs non-overlap
    send(7, 16'b1001001);
    check_val("t2_cnt_a", 32'(cnt_a), 32'd2);
    check_val("t2_cnt_b", 32'(cnt_b), 32'd1);
    do_reset();

    // en=0 gap with toggling data is transparent
    send(2, 16'b10);
    for (int k = 0; k < 3; k++) step(1'b0, k[0], 1'b0, 4'h0, 1'b0);
    send(2, 16'b01);
    check_val("t3_out_a", 32'(out_a), 32'd1);
    do_reset();

    // partial match before reset is lost; 0001 must not match zero history
    send(3, 16'b100);
    do_reset();
    send(1, 16'b1);
    check_val("t5_out_c", 32'(out_c), 32'd0);
    do_reset();

    // counter saturation and clear-with-match
    for (int k = 0; k < 4; k++) send(4, 16'b1001);
    check_val("t6_cnt_b", 32'(cnt_b), 32'd3);
    check_val("t6_sat_b", 32'(sat_b), 32'd1);
    send(3, 16'b100);
    step(1'b1, 1'b1, 1'b0, 4'h0, 1'b1);
    check_val("t6_clr_cnt_b", 32'(cnt_b), 32'd1);
    check_val("t6_clr_sat_b", 32'(sat_b), 32'd0);

    // reload discards old prefix
    do_reset();
    send(3, 16'b100);
    step(1'b1, 1'b1, 1'b1, 4'b1101, 1'b0);
    send(4, 16'b1101);
    check_val("t4_cnt_a", 32'(cnt_a), 32'd1);

    // randomized traffic
    for (int k = 0; k < 800; k++) begin
      if ($urandom_range(0, 99) == 0) begin
        do_reset();
      end else begin
        step($urandom_range(0, 99) < 80, 1'($urandom_range(0, 1)),
             $urandom_range(0, 99) < 3, 4'($urandom_range(0, 15)),
             $urandom_range(0, 99) < 3);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
